// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter sharing one strided tile dcache port between NREQ requesters.
// Drives the cache with its pipeline skew and routes read tiles back to the issuer.
module dcache_port_arbiter #(
    parameter  int NREQ   = 2,
    parameter  int SZ     = 4,
    parameter  int LOGCNT = 5,
    parameter  int BITS   = 18,
    parameter  int RD_LAT = 4,
    localparam int AW     = 10 + LOGCNT,
    localparam int SW     = 9 + LOGCNT,
    localparam int DW     = BITS * SZ * SZ
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_lock,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*SW-1:0] req_stride_x,
    input  logic [NREQ*SW-1:0] req_stride_y,
    input  logic [NREQ*DW-1:0] req_dat_w,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_dat,
    output logic [AW-1:0]      c_addr,
    output logic [SW-1:0]      c_stride_x,
    output logic [SW-1:0]      c_stride_y,
    output logic [DW-1:0]      c_dat_w,
    output logic               c_we,
    input  logic [DW-1:0]      c_dat_r,
    output logic               busy
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NSTG = RD_LAT + 2;

    // One entry per issued access; entry k is valid in the cycle after edge E+k.
    typedef struct packed {
        logic          v;
        logic          we;
        logic [PW-1:0] id;
    } iss_t;

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] lock_id_q, lock_id_d;
    logic          lock_valid_q, lock_valid_d;
    logic [AW-1:0] c_addr_q, c_addr_d;
    logic [SW-1:0] c_stride_x_q, c_stride_x_d;
    logic [SW-1:0] c_stride_y_q, c_stride_y_d;
    logic [DW-1:0] s1_dat_q, s1_dat_d;
    logic [DW-1:0] c_dat_w_q, c_dat_w_d;
    iss_t [NSTG-1:0] iss_q, iss_d;

    logic          gnt_found;
    logic [PW-1:0] gnt_id;
    int            idx;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_id    = '0;
        idx       = 0;
        if (en) begin
            if (lock_valid_q && req_valid[lock_id_q]) begin
                gnt_found = 1'b1;
                gnt_id    = lock_id_q;
            end else begin
                for (int i = 1; i <= NREQ; i++) begin
                    idx = (int'(ptr_q) + i) % NREQ;
                    if (!gnt_found && req_valid[idx]) begin
                        gnt_found = 1'b1;
                        gnt_id    = PW'(idx);
                    end
                end
            end
        end
        req_ready = '0;
        if (gnt_found) req_ready[gnt_id] = 1'b1;
    end

    always_comb begin
        ptr_d        = ptr_q;
        lock_valid_d = 1'b0;
        lock_id_d    = lock_id_q;
        c_addr_d     = c_addr_q;
        c_stride_x_d = c_stride_x_q;
        c_stride_y_d = c_stride_y_q;
        s1_dat_d     = s1_dat_q;
        c_dat_w_d    = c_dat_w_q;

        iss_d[0] = '0;
        for (int s = 1; s < NSTG; s++) iss_d[s] = iss_q[s-1];

        if (gnt_found) begin
            ptr_d        = gnt_id;
            lock_valid_d = req_lock[gnt_id];
            lock_id_d    = gnt_id;
            c_addr_d     = req_addr[gnt_id*AW +: AW];
            c_stride_x_d = req_stride_x[gnt_id*SW +: SW];
            c_stride_y_d = req_stride_y[gnt_id*SW +: SW];
            s1_dat_d     = req_dat_w[gnt_id*DW +: DW];
            iss_d[0]     = '{v: 1'b1, we: req_we[gnt_id], id: gnt_id};
        end

        // Write data lands one cycle after the address; reads leave it untouched.
        if (iss_q[0].v && iss_q[0].we) c_dat_w_d = s1_dat_q;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ptr_q        <= PW'(NREQ - 1);
            lock_valid_q <= 1'b0;
            lock_id_q    <= '0;
            c_addr_q     <= '0;
            c_stride_x_q <= '0;
            c_stride_y_q <= '0;
            s1_dat_q     <= '0;
            c_dat_w_q    <= '0;
            iss_q        <= '0;
        end else begin
            ptr_q        <= ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
            c_addr_q     <= c_addr_d;
            c_stride_x_q <= c_stride_x_d;
            c_stride_y_q <= c_stride_y_d;
            s1_dat_q     <= s1_dat_d;
            c_dat_w_q    <= c_dat_w_d;
            iss_q        <= iss_d;
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (iss_q[NSTG-1].v && !iss_q[NSTG-1].we) rsp_valid[iss_q[NSTG-1].id] = 1'b1;
        busy = 1'b0;
        for (int s = 0; s < NSTG; s++) busy = busy | iss_q[s].v;
    end

    assign c_addr     = c_addr_q;
    assign c_stride_x = c_stride_x_q;
    assign c_stride_y = c_stride_y_q;
    assign c_dat_w    = c_dat_w_q;
    assign c_we       = iss_q[2].v & iss_q[2].we;
    assign rsp_dat    = c_dat_r;

endmodule
